// File: rtl/mig_ui_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mig_ui_pkg
// Purpose  : Shared definitions for the MIG user-interface arbiter slice.
//            Contains the app_cmd opcodes, the sequencer state encoding and
//            the default UI address/data widths.
// Revision : 1.0 - initial release
// ============================================================================
package mig_ui_pkg;

    localparam int DEF_ADDR_W = 27;
    localparam int DEF_DATA_W = 128;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mig_rd_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mig_rd_tag_fifo
// Purpose  : Synchronous 1-bit-wide FIFO holding the requester ID of every
//            outstanding MIG read, in issue order.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            push, din         - enqueue din (ignored when full and not popping)
//            pop, dout         - dequeue; dout is the head entry
//            count, empty, full- occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module mig_rd_tag_fifo
    import mig_ui_pkg::*;
#(
    parameter int RD_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        din,
    input  logic                        pop,
    output logic                        dout,
    output logic [$clog2(RD_DEPTH):0]   count,
    output logic                        empty,
    output logic                        full
);

    localparam int PTR_W = $clog2(RD_DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(RD_DEPTH);

    logic               r_mem [RD_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_push = push & (~full | pop);
    assign w_pop  = pop & ~empty;

    // RD_DEPTH is a power of two, so the pointers wrap at RD_DEPTH naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == C_DEPTH);

endmodule
`default_nettype wire

// File: rtl/mig_ui_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mig_ui_arbiter
// Purpose  : Round-robin arbiter of two single-beat requesters onto one MIG
//            user interface. Each transaction runs a command phase and, for
//            writes, a write-data phase. Read requester IDs are queued in a
//            tag FIFO so in-order MIG read data returns to the issuing port.
// Ports    : clk, rst, init_calib_complete
//            req0_* / req1_*   - requester handshake (valid/ready/wr/addr/wdata)
//            rsp0_* / rsp1_*   - registered read-data return per port
//            app_*             - MIG UI command, write-data and read-data
//            rd_err            - sticky: read data arrived with no tag queued
// Revision : 1.0 - initial release
// ============================================================================
module mig_ui_arbiter
    import mig_ui_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_calib_complete,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_wr,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_rdata,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_wr,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_rdata,

    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid,

    output logic                rd_err
);

    localparam int CNT_W = $clog2(RD_DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(RD_DEPTH);

    state_t             r_state;
    logic               r_last_grant;
    logic               r_hold_wr;
    logic               r_hold_port;
    logic               r_app_en;
    logic [2:0]         r_app_cmd;
    logic [ADDR_W-1:0]  r_app_addr;
    logic [DATA_W-1:0]  r_wdf_data;
    logic               r_wdf_wren;
    logic               r_rsp0_valid;
    logic               r_rsp1_valid;
    logic [DATA_W-1:0]  r_rsp0_rdata;
    logic [DATA_W-1:0]  r_rsp1_rdata;
    logic               r_rd_err;

    logic [CNT_W-1:0]   w_tag_count;
    logic               w_tag_empty;
    logic               w_tag_full;
    logic               w_tag_dout;
    logic               w_tag_push;
    logic               w_tag_pop;
    logic               w_elig0;
    logic               w_elig1;
    logic               w_can_grant;
    logic               w_grant0;
    logic               w_grant1;

    // A read is only eligible while a tag slot is free; writes never need one.
    assign w_elig0 = req0_valid & (req0_wr | (w_tag_count < C_DEPTH));
    assign w_elig1 = req1_valid & (req1_wr | (w_tag_count < C_DEPTH));

    assign w_can_grant = (r_state == ST_IDLE) & init_calib_complete & ~rst;

    // On a tie the port that did not win last time is served.
    assign w_grant0 = w_can_grant & w_elig0 & (~w_elig1 | r_last_grant);
    assign w_grant1 = w_can_grant & w_elig1 & (~w_elig0 | ~r_last_grant);

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;

    // The tag is queued when the MIG accepts the read command, not at grant.
    assign w_tag_push = (r_state == ST_CMD) & app_rdy & ~r_hold_wr & ~w_tag_full;
    assign w_tag_pop  = app_rd_data_valid & ~w_tag_empty;

    mig_rd_tag_fifo #(
        .RD_DEPTH (RD_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_tag_push),
        .din   (r_hold_port),
        .pop   (w_tag_pop),
        .dout  (w_tag_dout),
        .count (w_tag_count),
        .empty (w_tag_empty),
        .full  (w_tag_full)
    );

    // Transaction sequencer; all MIG-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_hold_wr    <= 1'b0;
            r_hold_port  <= 1'b0;
            r_app_en     <= 1'b0;
            r_app_cmd    <= 3'b000;
            r_app_addr   <= '0;
            r_wdf_data   <= '0;
            r_wdf_wren   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_state      <= ST_CMD;
                        r_last_grant <= w_grant1;
                        r_hold_port  <= w_grant1;
                        r_hold_wr    <= w_grant1 ? req1_wr : req0_wr;
                        r_app_en     <= 1'b1;
                        r_app_cmd    <= (w_grant1 ? req1_wr : req0_wr) ? APP_CMD_WRITE : APP_CMD_READ;
                        r_app_addr   <= w_grant1 ? req1_addr : req0_addr;
                        r_wdf_data   <= w_grant1 ? req1_wdata : req0_wdata;
                    end
                end
                ST_CMD: begin
                    if (app_rdy) begin
                        r_app_en <= 1'b0;
                        if (r_hold_wr) begin
                            r_state    <= ST_WDATA;
                            r_wdf_wren <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_WDATA: begin
                    if (app_wdf_rdy) begin
                        r_state    <= ST_IDLE;
                        r_wdf_wren <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read return: route by the popped tag; unexpected data only flags rd_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
            r_rd_err     <= 1'b0;
        end else begin
            r_rsp0_valid <= w_tag_pop & ~w_tag_dout;
            r_rsp1_valid <= w_tag_pop &  w_tag_dout;
            if (w_tag_pop & ~w_tag_dout) r_rsp0_rdata <= app_rd_data;
            if (w_tag_pop &  w_tag_dout) r_rsp1_rdata <= app_rd_data;
            if (app_rd_data_valid & w_tag_empty) r_rd_err <= 1'b1;
        end
    end

    assign app_en       = r_app_en;
    assign app_cmd      = r_app_cmd;
    assign app_addr     = r_app_addr;
    assign app_wdf_data = r_wdf_data;
    assign app_wdf_wren = r_wdf_wren;
    assign app_wdf_end  = r_wdf_wren;
    assign rsp0_valid   = r_rsp0_valid;
    assign rsp1_valid   = r_rsp1_valid;
    assign rsp0_rdata   = r_rsp0_rdata;
    assign rsp1_rdata   = r_rsp1_rdata;
    assign rd_err       = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_mig_ui_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mig_ui_arbiter
// Purpose  : Self-checking bench for mig_ui_arbiter. A transaction-level
//            model (queues of pending commands, write data and read tags)
//            predicts every output each cycle; directed phases add literal
//            expectations for calibration gating, stalls, round-robin order,
//            read routing, tag-FIFO back-pressure, rd_err and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mig_ui_arbiter;

    localparam int ADDR_W   = 27;
    localparam int DATA_W   = 128;
    localparam int RD_DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               init_calib_complete = 1'b0;
    logic               req0_valid = 1'b0, req0_wr = 1'b0;
    logic [ADDR_W-1:0]  req0_addr = '0;
    logic [DATA_W-1:0]  req0_wdata = '0;
    logic               req1_valid = 1'b0, req1_wr = 1'b0;
    logic [ADDR_W-1:0]  req1_addr = '0;
    logic [DATA_W-1:0]  req1_wdata = '0;
    logic               app_rdy = 1'b0, app_wdf_rdy = 1'b0, app_rd_data_valid = 1'b0;
    logic [DATA_W-1:0]  app_rd_data = '0;

    logic               req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0]  rsp0_rdata, rsp1_rdata, app_wdf_data;
    logic               app_en, app_wdf_wren, app_wdf_end, rd_err;
    logic [2:0]         app_cmd;
    logic [ADDR_W-1:0]  app_addr;

    mig_ui_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_DEPTH(RD_DEPTH)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
        int                 port;
    } txn_t;

    txn_t               m_cmd_q[$];     // granted, command not yet accepted
    logic [DATA_W-1:0]  m_wd_q[$];      // write data awaiting acceptance
    int                 m_tags[$];      // outstanding reads, issue order
    int                 m_last;
    logic               m_err, m_rv0, m_rv1;
    logic [DATA_W-1:0]  m_rd0, m_rd1;
    int                 m_g, m_p;
    logic               m_busy, m_el0, m_el1;
    txn_t               m_t;

    task automatic m_reset();
        m_cmd_q.delete(); m_wd_q.delete(); m_tags.delete();
        m_last = 1; m_err = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        m_rd0 = '0; m_rd1 = '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                m_reset();
            end else begin
                m_busy = (m_cmd_q.size() != 0) || (m_wd_q.size() != 0);
                m_el0  = req0_valid && (req0_wr || m_tags.size() < RD_DEPTH);
                m_el1  = req1_valid && (req1_wr || m_tags.size() < RD_DEPTH);
                m_g = -1;
                if (!m_busy && init_calib_complete) begin
                    if (m_el0 && m_el1) m_g = (m_last == 0) ? 1 : 0;
                    else if (m_el0)     m_g = 0;
                    else if (m_el1)     m_g = 1;
                end
                check("req0_ready", req0_ready, m_g == 0);
                check("req1_ready", req1_ready, m_g == 1);
                check("app_en", app_en, m_cmd_q.size() != 0);
                if (m_cmd_q.size() != 0) begin
                    check("app_cmd", app_cmd, m_cmd_q[0].wr ? 3'b000 : 3'b001);
                    check("app_addr", app_addr, m_cmd_q[0].addr);
                end
                check("app_wdf_wren", app_wdf_wren, m_wd_q.size() != 0);
                check("app_wdf_end", app_wdf_end, m_wd_q.size() != 0);
                if (m_wd_q.size() != 0) check("app_wdf_data", app_wdf_data, m_wd_q[0]);
                check("rsp0_valid", rsp0_valid, m_rv0);
                check("rsp1_valid", rsp1_valid, m_rv1);
                if (m_rv0) check("rsp0_rdata", rsp0_rdata, m_rd0);
                if (m_rv1) check("rsp1_rdata", rsp1_rdata, m_rd1);
                check("rd_err", rd_err, m_err);

                // advance: return uses the tag queue before this cycle's push
                m_rv0 = 1'b0; m_rv1 = 1'b0;
                if (app_rd_data_valid) begin
                    if (m_tags.size() != 0) begin
                        m_p = m_tags.pop_front();
                        if (m_p == 0) begin m_rv0 = 1'b1; m_rd0 = app_rd_data; end
                        else          begin m_rv1 = 1'b1; m_rd1 = app_rd_data; end
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (m_cmd_q.size() != 0 && app_rdy) begin
                    m_t = m_cmd_q.pop_front();
                    if (m_t.wr) m_wd_q.push_back(m_t.data);
                    else        m_tags.push_back(m_t.port);
                end else if (m_wd_q.size() != 0 && app_wdf_rdy) begin
                    void'(m_wd_q.pop_front());
                end
                if (m_g >= 0) begin
                    m_t.wr   = (m_g == 1) ? req1_wr    : req0_wr;
                    m_t.addr = (m_g == 1) ? req1_addr  : req0_addr;
                    m_t.data = (m_g == 1) ? req1_wdata : req0_wdata;
                    m_t.port = m_g;
                    m_cmd_q.push_back(m_t);
                    m_last = m_g;
                end
            end
        end
    end

    // ---------------- event counters for directed expectations ----------------
    int                 n_g0 = 0, n_g1 = 0, n_en = 0, n_wren = 0, n_cmd_acc = 0, n_wd_acc = 0;
    int                 grant_log[$];
    logic [ADDR_W-1:0]  last_cmd_addr = '0;
    logic [DATA_W-1:0]  last_wd_data = '0;

    always @(negedge clk) begin
        if (req0_ready) begin n_g0++; grant_log.push_back(0); end
        if (req1_ready) begin n_g1++; grant_log.push_back(1); end
        if (app_en) n_en++;
        if (app_en && app_rdy) begin n_cmd_acc++; last_cmd_addr = app_addr; end
        if (app_wdf_wren) n_wren++;
        if (app_wdf_wren && app_wdf_rdy) begin n_wd_acc++; last_wd_data = app_wdf_data; end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(input int p, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) got = 1'b1;
            tick();
        end
        check({nm, " grant"}, got, 1'b1);
    endtask

    task automatic read_return(input logic [DATA_W-1:0] d);
        app_rd_data_valid = 1'b1; app_rd_data = d;
        tick();
        app_rd_data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int exp_rr [4] = '{0, 1, 0, 1};
    int got_rr;

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        #1;
        check("reset app_en", app_en, 1'b0);
        check("reset wren", app_wdf_wren, 1'b0);
        check("reset wdf_end", app_wdf_end, 1'b0);
        check("reset req0_ready", req0_ready, 1'b0);
        check("reset req1_ready", req1_ready, 1'b0);
        check("reset rsp0_valid", rsp0_valid, 1'b0);
        check("reset rsp1_valid", rsp1_valid, 1'b0);
        check("reset rd_err", rd_err, 1'b0);

        // ---- calibration gating + write with stalls ----
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 27'h00020C0; req0_wdata = {16{8'hA5}};
        n_g0 = 0; n_g1 = 0; n_en = 0; n_wren = 0; n_cmd_acc = 0; n_wd_acc = 0;
        repeat (20) tick();
        check("calib gate grants", n_g0 + n_g1, 0);
        check("calib gate app_en", n_en, 0);
        init_calib_complete = 1'b1;
        #1;
        check("calib req0_ready", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("calib app_en", app_en, 1'b1);
        check("calib app_cmd", app_cmd, 3'b000);
        check("calib app_addr", app_addr, 27'h00020C0);
        repeat (3) tick();
        app_rdy = 1'b1;
        tick();
        app_rdy = 1'b0;
        repeat (2) tick();
        app_wdf_rdy = 1'b1;
        tick();
        app_wdf_rdy = 1'b0;
        repeat (3) tick();
        check("stall app_en cycles", n_en, 4);
        check("stall wren cycles", n_wren, 3);
        check("stall cmd transfers", n_cmd_acc, 1);
        check("stall data transfers", n_wd_acc, 1);
        check("stall cmd addr", last_cmd_addr, 27'h00020C0);
        check("stall wdf data", last_wd_data, {16{8'hA5}});

        // ---- round-robin after reset ----
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 27'h0000100;
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 27'h0000200;
        grant_log.delete();
        for (int i = 0; i < 40 && grant_log.size() < 4; i++) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("rr grant count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got_rr = (i < grant_log.size()) ? grant_log[i] : -1;
            check("rr order", got_rr, exp_rr[i]);
        end
        repeat (2) tick();
        for (int i = 0; i < 4; i++) read_return(128'h1000 + i);
        repeat (2) tick();

        // ---- read routing ----
        req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 27'h00010E0;
        wait_grant(1, "route p1");
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 27'h00060C0;
        wait_grant(0, "route p0");
        req0_valid = 1'b0;
        repeat (2) tick();
        app_rd_data_valid = 1'b1; app_rd_data = {4{32'hD1D1_0001}};
        tick();
        app_rd_data = {4{32'hD0D0_0000}};
        #1;
        check("route rsp1_valid", rsp1_valid, 1'b1);
        check("route rsp1_rdata", rsp1_rdata, {4{32'hD1D1_0001}});
        check("route rsp0 idle", rsp0_valid, 1'b0);
        tick();
        app_rd_data_valid = 1'b0;
        #1;
        check("route rsp0_valid", rsp0_valid, 1'b1);
        check("route rsp0_rdata", rsp0_rdata, {4{32'hD0D0_0000}});
        check("route rsp1 idle", rsp1_valid, 1'b0);

        // ---- tag FIFO full ----
        tick();
        req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 27'h0000300;
        n_g0 = 0;
        for (int i = 0; i < 60 && n_g0 < RD_DEPTH; i++) tick();
        req0_valid = 1'b0;
        check("full reads issued", n_g0, RD_DEPTH);
        repeat (2) tick();
        req0_valid = 1'b1; req0_addr = 27'h0000340;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 27'h0000380; req1_wdata = 128'hBEEF;
        n_g0 = 0; n_g1 = 0;
        wait_grant(1, "full write");
        req1_valid = 1'b0;
        repeat (6) tick();
        check("full read blocked", n_g0, 0);
        check("full write granted", n_g1, 1);
        read_return(128'h5000);
        wait_grant(0, "full read after pop");
        req0_valid = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < RD_DEPTH; i++) read_return(128'h6000 + i);
        repeat (2) tick();

        // ---- rd_err on unexpected data ----
        read_return(128'hDEAD);
        #1;
        check("err rd_err", rd_err, 1'b1);
        check("err rsp0 idle", rsp0_valid, 1'b0);
        check("err rsp1 idle", rsp1_valid, 1'b0);

        // ---- reset during WDATA ----
        tick();
        app_wdf_rdy = 1'b0;
        req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 27'h0000400; req1_wdata = 128'h1234;
        wait_grant(1, "rst write");
        req1_valid = 1'b0;
        tick();
        #1;
        check("pre-reset wren", app_wdf_wren, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        #1;
        check("rst app_en", app_en, 1'b0);
        check("rst app_addr", app_addr, 27'h0);
        check("rst wren", app_wdf_wren, 1'b0);
        check("rst wdf_end", app_wdf_end, 1'b0);
        check("rst rd_err", rd_err, 1'b0);
        check("rst req1_ready", req1_ready, 1'b0);
        check("rst rsp valid", {rsp0_valid, rsp1_valid}, 2'b00);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
